// File: rtl/alu_muldiv.sv
// Single-issue ALU with multiply and optional multi-cycle restoring divider.
// Define ALU_MULDIV_DIV_EN to build the divider; otherwise ops 20-23 report illegal.
module alu_muldiv #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [4:0]            op_i,
   input  logic [DATA_WIDTH-1:0] op1_i,
   input  logic [DATA_WIDTH-1:0] op2_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  cmp_o,
   output logic                  illegal_o
);

   localparam int W   = DATA_WIDTH;
   localparam int SHW = $clog2(W);
   localparam int CW  = SHW + 1;

   // Handshake: a request is taken on a rising edge with valid_i && ready_o;
   // a result leaves on a rising edge with valid_o && ready_i.
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   result_q, result_d;
   logic           cmp_q, cmp_d, illegal_q, illegal_d;
   logic           accept, div_start, div_done;
   logic [W-1:0]   alu_res;
   logic           alu_cmp, alu_ill;
   logic [SHW-1:0] shamt;
   logic [2*W-1:0] mul_a, mul_b, prod;

`ifdef ALU_MULDIV_DIV_EN
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
   logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, is_rem_q, is_rem_d;
   logic [W:0]    rem_sh, trial;
   logic          div_sgn;
`endif

   assign accept = valid_i && (state_q == IDLE);
   assign shamt  = op2_i[SHW-1:0];

   always_comb begin
      mul_a = {{W{(op_i == 5'd17 || op_i == 5'd18) && op1_i[W-1]}}, op1_i};
      mul_b = {{W{(op_i == 5'd17) && op2_i[W-1]}}, op2_i};
      prod  = mul_a * mul_b;
   end

   always_comb begin
      alu_res   = '0;
      alu_cmp   = 1'b0;
      alu_ill   = 1'b0;
      div_start = 1'b0;
      case (op_i)
         5'd0:  alu_res = op1_i + op2_i;
         5'd1:  alu_res = op1_i - op2_i;
         5'd2:  alu_res = op1_i & op2_i;
         5'd3:  alu_res = op1_i | op2_i;
         5'd4:  alu_res = op1_i ^ op2_i;
         5'd5:  alu_res = {{(W-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
         5'd6:  alu_res = {{(W-1){1'b0}}, op1_i < op2_i};
         5'd7:  alu_res = op1_i << shamt;
         5'd8:  alu_res = op1_i >> shamt;
         5'd9:  alu_res = $signed(op1_i) >>> shamt;
         5'd10: alu_cmp = op1_i == op2_i;
         5'd11: alu_cmp = op1_i != op2_i;
         5'd12: alu_cmp = $signed(op1_i) < $signed(op2_i);
         5'd13: alu_cmp = $signed(op1_i) >= $signed(op2_i);
         5'd14: alu_cmp = op1_i < op2_i;
         5'd15: alu_cmp = op1_i >= op2_i;
         5'd16: alu_res = prod[W-1:0];
         5'd17, 5'd18, 5'd19: alu_res = prod[2*W-1:W];
`ifdef ALU_MULDIV_DIV_EN
         5'd20, 5'd21, 5'd22, 5'd23: begin
            // Zero divisor and signed overflow finish in one cycle without the divider.
            if (op2_i == '0)
               alu_res = op_i[1] ? op1_i : '1;
            else if (!op_i[0] && op1_i == MIN_NEG && op2_i == '1)
               alu_res = op_i[1] ? '0 : op1_i;
            else
               div_start = 1'b1;
         end
`endif
         default: alu_ill = 1'b1;
      endcase
   end

`ifdef ALU_MULDIV_DIV_EN
   assign div_done = (state_q == CALC) && (cnt_q == CW'(W));
   assign div_sgn  = !op_i[0];
   assign rem_sh   = {rem_q, quo_q[W-1]};
   assign trial    = rem_sh - {1'b0, dvs_q};
`else
   assign div_done = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         result_q  <= '0;
         cmp_q     <= 1'b0;
         illegal_q <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_rem_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         cmp_q     <= cmp_d;
         illegal_q <= illegal_d;
`ifdef ALU_MULDIV_DIV_EN
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         is_rem_q  <= is_rem_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = div_start ? CALC : DONE;
         CALC:    if (div_done) state_d = DONE;
         DONE:    if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      result_d  = result_q;
      cmp_d     = cmp_q;
      illegal_d = illegal_q;
`ifdef ALU_MULDIV_DIV_EN
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      is_rem_d  = is_rem_q;
`endif
      if (accept) begin
         result_d  = alu_res;
         cmp_d     = alu_cmp;
         illegal_d = alu_ill;
`ifdef ALU_MULDIV_DIV_EN
         // Divide magnitudes, then fix signs: quotient truncates toward zero.
         rem_d     = '0;
         cnt_d     = '0;
         quo_d     = (div_sgn && op1_i[W-1]) ? -op1_i : op1_i;
         dvs_d     = (div_sgn && op2_i[W-1]) ? -op2_i : op2_i;
         neg_quo_d = div_sgn && (op1_i[W-1] ^ op2_i[W-1]);
         neg_rem_d = div_sgn && op1_i[W-1];
         is_rem_d  = op_i[1];
      end else if (state_q == CALC) begin
         if (div_done) begin
            if (is_rem_q) result_d = neg_rem_q ? -rem_q : rem_q;
            else          result_d = neg_quo_q ? -quo_q : quo_q;
         end else begin
            rem_d = trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
            quo_d = {quo_q[W-2:0], ~trial[W]};
            cnt_d = cnt_q + CW'(1);
         end
`endif
      end
   end

   always_comb begin
      ready_o   = (state_q == IDLE);
      valid_o   = (state_q == DONE);
      result_o  = result_q;
      cmp_o     = cmp_q;
      illegal_o = illegal_q;
   end

endmodule
